// File: rtl/parity_chk_pkg.sv
// Shared definitions for the serial parity-checking receiver.
// Holds the receiver state encoding, the default word width and a small
// width helper used by the top level.
package parity_chk_pkg;

  // Default number of data bits per frame.
  localparam int DATA_W_DEF = 8;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Bit-counter width: must represent 0..data_w without wrapping.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage : parity_chk_pkg

// File: rtl/parity_chk_rx_parity_acc.sv
// Running XNOR parity accumulator.
// clr loads 1 (the XNOR seed), en folds d into the running value.
// Reset clears the accumulator to 0.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic p
);

  // Accumulator register; clr has priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= 1'b0;
    end else if (clr) begin
      p <= 1'b1;
    end else if (en) begin
      p <= p ^ d;
    end
  end

endmodule : parity_acc

// File: rtl/parity_chk_rx.sv
// Serial frame receiver with XNOR parity and stop-bit checking.
// Frame: start(0), DATA_W data bits LSB first, parity, stop(1). Only
// cycles with bit_vld=1 advance the receiver.
// Optional feature: define PARITY_CHK_ERR_CNT_EN to add an 8-bit saturating
// error counter output err_cnt.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a qualified 0 (start bit); qualified 1s ignored
// DATA  | shifting in DATA_W data bits, LSB first
// PAR   | sampling the parity bit against the accumulator
// STOP  | sampling the stop bit, publishing the word and status
module parity_chk_rx
  import parity_chk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_vld,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic              par_ok,
`ifdef PARITY_CHK_ERR_CNT_EN
  output logic              frame_err,
  output logic [7:0]        err_cnt
`else
  output logic              frame_err
`endif
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_pend;

  logic              w_start;
  logic              w_data_en;
  logic              w_last;
  logic              w_p;
  logic [DATA_W-1:0] w_shift_nxt;

  // A qualified 0 in IDLE starts a frame and reseeds the accumulator.
  assign w_start   = (r_state == IDLE) && bit_vld && !bit_in;
  assign w_data_en = (r_state == DATA) && bit_vld;
  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

  // Right shift with the new bit entering at the MSB, so after DATA_W bits
  // the first-received bit sits at bit 0.
  always_comb begin
    w_shift_nxt = '0;
    for (int i = 0; i < DATA_W - 1; i++) begin
      w_shift_nxt[i] = r_shift[i+1];
    end
    w_shift_nxt[DATA_W-1] = bit_in;
  end

  parity_acc u_parity_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (w_data_en),
    .d   (bit_in),
    .p   (w_p)
  );

  // Receiver FSM with registered outputs. The parity verdict is held in
  // r_par_pend until the stop bit so par_ok only changes at frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      data_out   <= '0;
      data_vld   <= 1'b0;
      par_ok     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (bit_vld) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= PAR;
            end
          end
        end
        PAR: begin
          if (bit_vld) begin
            r_par_pend <= (bit_in == w_p);
            r_state    <= STOP;
          end
        end
        STOP: begin
          if (bit_vld) begin
            data_out  <= r_shift;
            par_ok    <= r_par_pend;
            frame_err <= ~bit_in;
            data_vld  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef PARITY_CHK_ERR_CNT_EN
  // Count completed frames with a parity or framing error, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (data_vld && (!par_ok || frame_err) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule : parity_chk_rx
